// File: rtl/oric_tape_pkg.sv
// Shared constants for the Oric tape loader: FSM encoding, autorun code and
// byte offsets within a TAP header (counted from the first byte after the sync marker).
package oric_tape_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERROR   = 3'd5;

    localparam logic [7:0] TAP_AUTORUN_CODE = 8'hC7;

    localparam int unsigned TAP_HDR_OFF_TYPE     = 2;
    localparam int unsigned TAP_HDR_OFF_AUTORUN  = 3;
    localparam int unsigned TAP_HDR_OFF_END_HI   = 4;
    localparam int unsigned TAP_HDR_OFF_END_LO   = 5;
    localparam int unsigned TAP_HDR_OFF_START_HI = 6;
    localparam int unsigned TAP_HDR_OFF_START_LO = 7;
    localparam int unsigned TAP_HDR_OFF_NAME     = 9;

endpackage

// File: rtl/tap_ram_writer.sv
// Copies a TAP program body from the tape cache into RAM, one byte per
// fetch/capture/write round trip, and reports completion, autorun or error.
module tap_ram_writer
    import oric_tape_pkg::*;
#(
    parameter int         CACHE_AW     = 16,
    parameter logic [7:0] AUTORUN_CODE = TAP_AUTORUN_CODE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hdr_valid,
    input  logic [15:0]         hdr_start,
    input  logic [15:0]         hdr_end,
    input  logic [7:0]          hdr_autorun,
    input  logic [CACHE_AW-1:0] hdr_data_off,
    input  logic                abort,
    output logic [CACHE_AW-1:0] cache_addr,
    output logic                cache_cs,
    input  logic [7:0]          cache_dout,
    output logic [15:0]         ram_addr,
    output logic [7:0]          ram_dout,
    output logic                ram_wr,
    input  logic                ram_grant,
    output logic                busy,
    output logic                tape_complete,
    output logic                tape_autorun,
    output logic                tape_error
);

    logic [STATE_W-1:0] state;
    logic [15:0]        wptr;
    logic [15:0]        end_q;
    logic [7:0]         autorun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wptr       <= '0;
            end_q      <= '0;
            autorun_q  <= '0;
            cache_addr <= '0;
            ram_addr   <= '0;
            ram_dout   <= '0;
            ram_wr     <= 1'b0;
            tape_error <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            // A grant on this same cycle has already completed its write.
            state  <= ST_IDLE;
            ram_wr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hdr_valid) begin
                        end_q      <= hdr_end;
                        autorun_q  <= hdr_autorun;
                        tape_error <= 1'b0;
                        wptr       <= hdr_start;
                        cache_addr <= hdr_data_off;
                        state      <= (hdr_end < hdr_start) ? ST_ERROR : ST_FETCH;
                    end
                end
                ST_FETCH:   state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    ram_dout <= cache_dout;
                    ram_addr <= wptr;
                    ram_wr   <= 1'b1;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (ram_grant) begin
                        ram_wr <= 1'b0;
                        // Compare before incrementing so an end of FFFF never wraps wptr.
                        if (wptr == end_q) begin
                            state <= ST_DONE;
                        end else begin
                            wptr       <= wptr + 16'd1;
                            cache_addr <= cache_addr + 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERROR: begin
                    tape_error <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        cache_cs      = (state == ST_FETCH);
        tape_complete = (state == ST_DONE);
        tape_autorun  = (state == ST_DONE) && (autorun_q == AUTORUN_CODE);
    end

endmodule

// File: tb/tb_tap_ram_writer.sv
// Directed and randomized loads against a byte-level model of the tape-cache-to-RAM copy.
module tb_tap_ram_writer;
    import oric_tape_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hdr_valid = 1'b0;
    logic [15:0]   hdr_start = '0;
    logic [15:0]   hdr_end = '0;
    logic [7:0]    hdr_autorun = '0;
    logic [AW-1:0] hdr_data_off = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] cache_addr;
    logic          cache_cs;
    logic [7:0]    cache_dout = '0;
    logic [15:0]   ram_addr;
    logic [7:0]    ram_dout;
    logic          ram_wr;
    logic          ram_grant = 1'b1;
    logic          busy, tape_complete, tape_autorun, tape_error;

    tap_ram_writer #(.CACHE_AW(AW), .AUTORUN_CODE(8'hC7)) dut (
        .clk(clk), .reset(reset), .hdr_valid(hdr_valid), .hdr_start(hdr_start),
        .hdr_end(hdr_end), .hdr_autorun(hdr_autorun), .hdr_data_off(hdr_data_off),
        .abort(abort), .cache_addr(cache_addr), .cache_cs(cache_cs),
        .cache_dout(cache_dout), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .ram_wr(ram_wr), .ram_grant(ram_grant), .busy(busy),
        .tape_complete(tape_complete), .tape_autorun(tape_autorun), .tape_error(tape_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  cache_mem [0:(1<<AW)-1];
    logic [23:0] wq[$];
    int complete_cnt = 0, autorun_cnt = 0, autorun_alone = 0, stab_bad = 0;
    int grant_mode = 0;

    // Cache returns data one cycle after a selected address.
    always @(posedge clk) if (cache_cs) cache_dout <= cache_mem[cache_addr];

    always @(negedge clk) begin
        case (grant_mode)
            0: ram_grant = 1'b1;
            1: ram_grant = ~ram_grant;
            2: ram_grant = $urandom_range(0, 1) == 1;
            default: ram_grant = 1'b0;
        endcase
    end

    logic        p_wr = 0, p_gr = 0, p_ab = 0;
    logic [15:0] p_a = 0;
    logic [7:0]  p_d = 0;
    always @(posedge clk) begin
        if (!reset) begin
            if (ram_wr && ram_grant) wq.push_back({ram_addr, ram_dout});
            if (tape_complete) complete_cnt++;
            if (tape_autorun) autorun_cnt++;
            if (tape_autorun && !tape_complete) autorun_alone++;
            if (p_wr && !p_gr && !p_ab && !(ram_wr && ram_addr == p_a && ram_dout == p_d))
                stab_bad++;
        end
        p_wr = ram_wr && !reset; p_gr = ram_grant; p_ab = abort; p_a = ram_addr; p_d = ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [15:0] s, input logic [15:0] e,
                              input logic [7:0] a, input logic [AW-1:0] o);
        wq.delete();
        complete_cnt = 0; autorun_cnt = 0; autorun_alone = 0; stab_bad = 0;
        @(negedge clk);
        hdr_start = s; hdr_end = e; hdr_autorun = a; hdr_data_off = o; hdr_valid = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
    endtask

    // Returns cycles counted from the accepting edge until tape_complete is seen.
    task automatic wait_complete(input string tag, output int cycles);
        cycles = 0;
        while (tape_complete !== 1'b1 && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (tape_complete !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_load(input string tag, input logic [15:0] s, input logic [15:0] e,
                              input logic [7:0] a, input logic [AW-1:0] o);
        int n;
        n = int'({1'b0, e}) - int'({1'b0, s}) + 1;
        chk({tag, "_nwrites"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            logic [AW-1:0] ca;
            logic [15:0]   ra;
            ca = o + AW'(i);
            ra = s + 16'(i);
            chk({tag, "_write"}, wq[i], {ra, cache_mem[ca]});
        end
        chk({tag, "_complete"}, complete_cnt, 1);
        chk({tag, "_autorun"}, autorun_cnt, (a == 8'hC7) ? 1 : 0);
        chk({tag, "_autorun_alone"}, autorun_alone, 0);
        chk({tag, "_stable"}, stab_bad, 0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int cyc;
        logic [15:0] s, e;
        logic [7:0]  a;
        logic [AW-1:0] o;

        for (int i = 0; i < (1 << AW); i++) cache_mem[i] = 8'($urandom);
        cache_mem[16'h14] = 8'h11; cache_mem[16'h15] = 8'h22;
        cache_mem[16'h16] = 8'h33; cache_mem[16'h17] = 8'h44;

        #12;
        chk("rst_outputs", {cache_addr, ram_addr, ram_dout},
            '0);
        chk("rst_flags", {cache_cs, ram_wr, busy, tape_complete, tape_autorun, tape_error}, 0);
        @(negedge clk); reset = 1'b0;

        // Basic 4-byte load, grant tied high
        grant_mode = 0;
        start_load(16'h0500, 16'h0503, 8'h00, 16'h0014);
        wait_complete("basic", cyc);
        chk("basic_latency", cyc, 12);
        check_load("basic", 16'h0500, 16'h0503, 8'h00, 16'h0014);
        chk("basic_data0", wq.size() > 0 ? wq[0] : 0, 24'h050011);

        // Autorun with toggling grant
        grant_mode = 1;
        start_load(16'h0500, 16'h0503, 8'hC7, 16'h0014);
        wait_complete("toggle", cyc);
        check_load("toggle", 16'h0500, 16'h0503, 8'hC7, 16'h0014);

        // Single byte at the top of memory
        grant_mode = 0;
        start_load(16'hFFFF, 16'hFFFF, 8'h00, 16'h0100);
        wait_complete("top", cyc);
        check_load("top", 16'hFFFF, 16'hFFFF, 8'h00, 16'h0100);

        // Load running into FFFF while the cache address wraps
        grant_mode = 2;
        start_load(16'hFFFC, 16'hFFFF, 8'hC7, 16'hFFFE);
        wait_complete("wrap", cyc);
        check_load("wrap", 16'hFFFC, 16'hFFFF, 8'hC7, 16'hFFFE);

        // Reversed range
        start_load(16'h0600, 16'h05FF, 8'hC7, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("err_flag", tape_error, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_writes", wq.size(), 0);
        chk("err_complete", complete_cnt, 0);
        grant_mode = 0;
        start_load(16'h0700, 16'h0701, 8'h00, 16'h0040);
        chk("err_cleared", tape_error, 1'b0);
        wait_complete("after_err", cyc);
        check_load("after_err", 16'h0700, 16'h0701, 8'h00, 16'h0040);

        // hdr_valid while busy is ignored
        grant_mode = 2;
        start_load(16'h2000, 16'h2005, 8'h00, 16'h0300);
        repeat (4) @(posedge clk);
        @(negedge clk);
        hdr_start = 16'h3000; hdr_end = 16'h3000; hdr_data_off = 16'h0; hdr_autorun = 8'hC7;
        hdr_valid = 1'b1;
        @(negedge clk); hdr_valid = 1'b0;
        wait_complete("ignore", cyc);
        check_load("ignore", 16'h2000, 16'h2005, 8'h00, 16'h0300);

        // Abort after the second granted write of a 10-byte load
        grant_mode = 0;
        start_load(16'h1000, 16'h1009, 8'hC7, 16'h0200);
        cyc = 0;
        while (wq.size() < 2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_wr", ram_wr, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_writes", wq.size(), 2);
        chk("abort_complete", complete_cnt, 0);
        start_load(16'h1100, 16'h1102, 8'h00, 16'h0210);
        chk("abort_reaccept", busy, 1'b1);
        wait_complete("reaccept", cyc);
        check_load("reaccept", 16'h1100, 16'h1102, 8'h00, 16'h0210);

        // Randomized loads
        for (int t = 0; t < 12; t++) begin
            s = 16'($urandom);
            e = s + 16'($urandom_range(0, 9));
            if (e < s) e = 16'hFFFF;
            a = ($urandom_range(0, 1) == 1) ? 8'hC7 : 8'($urandom);
            o = AW'($urandom);
            grant_mode = $urandom_range(0, 2);
            start_load(s, e, a, o);
            wait_complete("rand", cyc);
            check_load("rand", s, e, a, o);
        end

        // Reset while a write waits for its grant
        grant_mode = 3;
        start_load(16'h4000, 16'h4003, 8'hC7, 16'h0000);
        cyc = 0;
        while (ram_wr !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("rst_mid_wr_pending", ram_wr, 1'b1);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_wr", ram_wr, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_addr", {cache_addr, ram_addr, ram_dout}, '0);
        chk("rst_mid_writes", wq.size(), 0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_quiet", {busy, ram_wr}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tap_ram_writer.md
TAP_RAM_WRITER -- requirements
Module: tap_ram_writer

Interface
REQ-001 Parameter CACHE_AW, default 16: tape-cache address width in bits.
REQ-002 Parameter AUTORUN_CODE, default 8'hC7: header autorun byte value that requests autorun.
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 hdr_valid  in  1  one-cycle pulse: header fields are valid and the load starts.
REQ-006 hdr_start  in  16  first RAM address (loadpoint).
REQ-007 hdr_end  in  16  last RAM address, inclusive.
REQ-008 hdr_autorun  in  8  raw header autorun byte.
REQ-009 hdr_data_off  in  CACHE_AW  cache address of the first program byte (first byte after the filename NUL).
REQ-010 abort  in  1  cancels a load in progress.
REQ-011 cache_addr  out  CACHE_AW  tape-cache read address.
REQ-012 cache_cs  out  1  cache read enable.
REQ-013 cache_dout  in  8  cache data; valid exactly 1 cycle after the address is presented with cache_cs=1.
REQ-014 ram_addr  out  16  RAM write address.
REQ-015 ram_dout  out  8  RAM write data.
REQ-016 ram_wr  out  1  write request; held until granted.
REQ-017 ram_grant  in  1  a write completes on any cycle with ram_wr=1 and ram_grant=1.
REQ-018 busy  out  1  high while the state is not IDLE.
REQ-019 tape_complete  out  1  one-cycle pulse when the last byte is written.
REQ-020 tape_autorun  out  1  one-cycle pulse, coincident with tape_complete, when hdr_autorun==AUTORUN_CODE.
REQ-021 tape_error  out  1  sticky error flag; cleared by the next accepted hdr_valid or by reset.

Function
REQ-022 States SHALL be IDLE, FETCH, CAPTURE, WRITE, DONE and ERROR.
REQ-023 IDLE: on hdr_valid, latch all hdr_* fields and clear tape_error; go to ERROR if hdr_end<hdr_start (unsigned), otherwise go to FETCH with cache_addr=hdr_data_off and wptr=hdr_start.
REQ-024 FETCH: assert cache_cs=1 for 1 cycle, then go to CAPTURE.
REQ-025 CAPTURE: register cache_dout into ram_dout, set ram_addr=wptr and ram_wr=1, then go to WRITE.
REQ-026 WRITE: hold ram_wr, ram_addr and ram_dout stable until the grant.
REQ-027 On a grant with wptr==end: ram_wr=0, go to DONE.
REQ-028 On a grant otherwise: wptr+1, cache_addr+1, go to FETCH.
REQ-029 Minimum cost SHALL be 3 cycles per byte with ram_grant tied high.
REQ-030 DONE: pulse tape_complete, and tape_autorun if flagged, for exactly 1 cycle, then go to IDLE.
REQ-031 ERROR: set tape_error=1, write nothing, go to IDLE next cycle, and never pulse tape_complete.
REQ-032 The end-of-load test SHALL compare before incrementing, so hdr_end=16'hFFFF writes address FFFF and the pointer never wraps to 0000.
REQ-033 hdr_start==hdr_end SHALL write exactly one byte.
REQ-034 cache_addr SHALL wrap modulo 2^CACHE_AW without flagging an error.
REQ-035 hdr_valid while busy SHALL be ignored.
REQ-036 abort in any non-IDLE state SHALL go to IDLE next cycle with ram_wr=0, no tape_complete pulse, and tape_error unchanged.
REQ-037 A write already granted on the same cycle as abort stands.
REQ-038 abort and hdr_valid together in IDLE: hdr_valid wins.
REQ-039 A byte count of 65536 (start 0000, end FFFF) SHALL be supported; length arithmetic is 17 bits wide.

Reset
REQ-040 Asserting reset SHALL immediately force state=IDLE and all outputs to 0, with cache_addr=0, ram_addr=0 and ram_dout=0.
REQ-041 Latched header registers SHALL reset to 0.
REQ-042 Reset asserted mid-load SHALL leave RAM contents as already written; no further write is issued.

Structure
REQ-043 State encoding and AUTORUN_CODE SHALL live in a shared package, oric_tape_pkg, together with the TAP header offset constants used by the header parser.
REQ-044 The design SHALL be a single module with no sub-module; the byte/address counter stays inline.

Verification
REQ-045 start=0x0500, end=0x0503, data_off=0x14, cache[0x14..0x17]=11 22 33 44, grant=1 -> 4 writes 0500:11 .. 0503:44, one tape_complete pulse 12 cycles plus DONE after hdr_valid, no tape_autorun.
REQ-046 Same load with hdr_autorun=C7 and grant toggling 1/0 each cycle -> identical writes, ram_wr/ram_addr/ram_dout stable while ungranted, tape_autorun coincident with tape_complete.
REQ-047 start=end=0xFFFF -> exactly one write to FFFF, no write to 0000, then tape_complete.
REQ-048 start=0x0600, end=0x05FF -> tape_error=1, no ram_wr, no tape_complete; a following valid load clears tape_error.
REQ-049 abort asserted after the 2nd granted write of a 10-byte load -> exactly 2 writes, busy low next cycle, no completion pulse; a new hdr_valid is accepted.
REQ-050 Reset asserted while ram_wr=1 and ungranted -> ram_wr drops asynchronously, state=IDLE, all outputs 0.
